// File: rtl/crc_pkg.sv
// Shared types, reference polynomials and helpers for the CRC engine.
package crc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } crc_state_t;

  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [63:0] bitrev(input logic [63:0] x, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(w)) r[i] = x[6'(int'(w) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_engine_if.sv
// Valid/ready word stream into the CRC engine.
interface crc_engine_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/crc_step.sv
// Folds BPC data bits (MSB of data first) into the CRC register in one cycle.
module crc_step #(
  parameter int unsigned CRC_W = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [CRC_W-1:0] poly,
  input  logic [BPC-1:0]   data,
  output logic [CRC_W-1:0] crc_nxt
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    fb = 1'b0;
    c  = crc_in;
    for (int i = int'(BPC) - 1; i >= 0; i--) begin
      fb = data[i] ^ c[CRC_W-1];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    crc_nxt = c;
  end

endmodule

// File: rtl/crc_engine.sv
// Programmable CRC engine: folds DATA_W-bit words BPC bits per cycle.
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BPC    = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             crc_init,
  input  logic [CRC_W-1:0] cfg_poly,
  input  logic [CRC_W-1:0] cfg_seed,
  input  logic [CRC_W-1:0] cfg_xorout,
  input  logic             cfg_reflect,
  crc_engine_if.slave      dbus,
  output logic             crc_done,
  output logic [CRC_W-1:0] crc_out
);

  localparam int unsigned STEPS = DATA_W / BPC;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((DATA_W % BPC) != 0) begin : g_bpc_chk
    $error("crc_engine: BPC must divide DATA_W");
  end
  if (CRC_W < 8 || CRC_W > 64) begin : g_crcw_chk
    $error("crc_engine: CRC_W must be within 8..64");
  end

  crc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic [CRC_W-1:0] xorout_q, xorout_d;
  logic             reflect_q, reflect_d;
  logic             done_q, done_d;
  logic             ready_c;
  logic             last_c;
  logic [DATA_W-1:0] swz_data;
  logic [CRC_W-1:0] step_crc;

  // Reflected mode feeds each byte LSB-first, so swap bits within every byte.
  for (genvar i = 0; i < DATA_W; i++) begin : g_swz
    localparam int unsigned J = (i / 8) * 8 + 7 - (i % 8);
    if (J < DATA_W) begin : g_in
      assign swz_data[i] = reflect_q ? dbus.in_data[J] : dbus.in_data[i];
    end else begin : g_keep
      assign swz_data[i] = dbus.in_data[i];
    end
  end

  crc_step #(
    .CRC_W (CRC_W),
    .BPC   (BPC)
  ) u_step (
    .crc_in  (crc_q),
    .poly    (poly_q),
    .data    (word_q[DATA_W-1 -: BPC]),
    .crc_nxt (step_crc)
  );

  assign last_c        = (cnt_q == CNT_W'(STEPS - 1));
  assign dbus.in_ready = ready_c;
  assign crc_done      = done_q;
  assign crc_out       = (reflect_q ? CRC_W'(bitrev(64'(crc_q), CRC_W)) : crc_q) ^ xorout_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      crc_q     <= '0;
      poly_q    <= '0;
      xorout_q  <= '0;
      reflect_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      crc_q     <= crc_d;
      poly_q    <= poly_d;
      xorout_q  <= xorout_d;
      reflect_q <= reflect_d;
      done_q    <= done_d;
    end
  end

  // Next state; init wins over everything and discards a partial word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    crc_d     = crc_q;
    poly_d    = poly_q;
    xorout_d  = xorout_q;
    reflect_d = reflect_q;
    done_d    = 1'b0;
    ready_c   = 1'b0;

    if (crc_init) begin
      crc_d     = cfg_seed;
      poly_d    = cfg_poly;
      xorout_d  = cfg_xorout;
      reflect_d = cfg_reflect;
      state_d   = IDLE;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_c = 1'b1;
          if (dbus.in_valid) begin
            word_d  = swz_data;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          crc_d  = step_crc;
          word_d = word_q << BPC;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_c) begin
            done_d  = 1'b1;
            ready_c = 1'b1;
            if (dbus.in_valid) begin
              word_d = swz_data;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
